// File: rtl/hex_str_render.sv
`default_nettype none
// ============================================================================
// Module   : hex_str_render
// Purpose  : Drives hex_ch one 8-pixel character row at a time to render a
//            DIGITS-nibble hex value as a pixel strip (x = digit*8+col, y = row).
// Options  : HEX_RENDER_LZB_EN -- blank leading zero digits (last digit kept).
// Revision : 1.0  initial release
// ============================================================================
module hex_str_render #(
  parameter int DIGITS   = 4,
  parameter int CH_W     = 4,
  parameter int CH_ROW_W = 3,
  parameter int CH_COL_W = 3,
  parameter int X_W      = $clog2(DIGITS*8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] value,
  output logic                busy,
  output logic                done,
  input  logic                burst_rdy,
  output logic [CH_W-1:0]     ch_sel,
  output logic [CH_ROW_W-1:0] row_sel,
  output logic                ch_px_rd,
  input  logic                ch_px_valid,
  input  logic                ch_px_out,
  output logic                px_valid,
  output logic                px_data,
  output logic [X_W-1:0]      px_x,
  output logic [CH_ROW_W-1:0] px_y
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIG_W-1:0] c_last_digit = DIG_W'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_READ     = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [4*DIGITS-1:0]   r_value;
  logic [DIG_W-1:0]      r_digit;
  logic [CH_ROW_W-1:0]   r_row;
  logic [CH_COL_W-1:0]   r_col;
  logic [CH_COL_W-1:0]   r_rd_cnt;
  logic [CH_W-1:0]       r_ch_sel;
  logic                  w_accept;
  logic                  w_rd_entry;
  logic                  w_burst_end;
  logic                  w_last_burst;
  logic                  w_digit_wrap;
  logic [DIG_W-1:0]      w_digit_nx;
  logic [CH_ROW_W-1:0]   w_row_nx;

  // Digit 0 is the most significant nibble.
  function automatic logic [3:0] f_nibble(input logic [4*DIGITS-1:0] v,
                                          input logic [DIG_W-1:0]    d);
    return v[4*(DIGITS-1-int'(d)) +: 4];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    ch_px_rd     = 1'b0;
    w_accept     = 1'b0;
    w_rd_entry   = 1'b0;
    // The 8th valid pixel of the burst closes DRAIN.
    w_burst_end  = (r_state == S_DRAIN) && ch_px_valid && (&r_col);
    w_last_burst = (r_digit == c_last_digit) && (&r_row);
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_WAIT_RDY;
        end else begin
          w_next   = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        busy = 1'b1;
        if (burst_rdy) begin
          w_rd_entry = 1'b1;
          w_next     = S_READ;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        ch_px_rd = 1'b1;
        if (&r_rd_cnt) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_burst_end) w_next = w_last_burst ? S_DONE : S_WAIT_RDY;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Digit is the inner loop, row the outer loop.
  assign w_digit_wrap = (r_digit == c_last_digit);
  assign w_digit_nx   = w_digit_wrap ? '0 : r_digit + DIG_W'(1);
  assign w_row_nx     = w_digit_wrap ? r_row + CH_ROW_W'(1) : r_row;

`ifdef HEX_RENDER_LZB_EN
  logic [DIGITS-1:0] w_lz_mask;
  logic              w_lz_seen;
  logic [DIGITS-1:0] r_blank;

  always_comb begin
    w_lz_seen = 1'b0;
    w_lz_mask = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (value[4*(DIGITS-1-d) +: 4] != 4'h0) w_lz_seen = 1'b1;
      w_lz_mask[d] = ~w_lz_seen && (d != DIGITS-1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value  <= '0;
      r_digit  <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_rd_cnt <= '0;
      r_ch_sel <= '0;
`ifdef HEX_RENDER_LZB_EN
      r_blank  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_value  <= value;
        r_digit  <= '0;
        r_row    <= '0;
        r_ch_sel <= CH_W'(f_nibble(value, '0));
`ifdef HEX_RENDER_LZB_EN
        r_blank  <= w_lz_mask;
`endif
      end else if (w_burst_end && !w_last_burst) begin
        r_digit  <= w_digit_nx;
        r_row    <= w_row_nx;
        r_ch_sel <= CH_W'(f_nibble(r_value, w_digit_nx));
      end
      if (w_rd_entry) begin
        r_col    <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (ch_px_rd) r_rd_cnt <= r_rd_cnt + CH_COL_W'(1);
        if (px_valid) r_col    <= r_col + CH_COL_W'(1);
      end
    end
  end

  assign ch_sel   = r_ch_sel;
  assign row_sel  = r_row;
  assign px_valid = ch_px_valid & busy;
`ifdef HEX_RENDER_LZB_EN
  assign px_data  = px_valid & ch_px_out & ~r_blank[r_digit];
`else
  assign px_data  = px_valid & ch_px_out;
`endif
  assign px_x     = X_W'({r_digit, r_col});
  assign px_y     = r_row;

endmodule
`default_nettype wire

// File: doc/hex_str_render.md
# hex_str_render

Sequencer that renders a `DIGITS`-nibble hexadecimal value as a text strip by driving the `hex_ch` character-pixel reader, one 8-pixel character row at a time. It sits between a display client, which supplies the value and a start pulse, and the display pixel writer, which consumes an (x, y, data) pixel stream with burst-level flow control. It owns the `hex_ch` select and read lines exclusively, and shares `clk`/`rst` with it.

## Interface
- `DIGITS`, 4: number of hex digits rendered; the leftmost digit is the MS nibble.
- `CH_W`, 4: `hex_ch` character select width.
- `CH_ROW_W`, 3: `hex_ch` row select width (8 rows).
- `CH_COL_W`, 3: pixel column width within a character (8 columns).
- `X_W`, `$clog2(DIGITS*8)`: strip x coordinate width.
- `clk` in 1: system clock. The block uses one clock.
- `rst` in 1: reset. It is synchronous and active-high.
- `start` in 1: render request, sampled when `busy`=0.
- `value` in `4*DIGITS`: value to render, latched on an accepted `start`.
- `busy` out 1: a render is in progress.
- `done` out 1: one-cycle pulse after the last pixel.
- `burst_rdy` in 1: the writer can accept 8 pixels.
- `ch_sel` out `CH_W`: `hex_ch` character select.
- `row_sel` out `CH_ROW_W`: `hex_ch` row select.
- `ch_px_rd` out 1: `hex_ch` read strobe.
- `ch_px_valid` in 1: `hex_ch` pixel valid.
- `ch_px_out` in 1: `hex_ch` pixel value. Column 0 (LSB) is delivered first.
- `px_valid` out 1: output pixel valid. Equals `ch_px_valid` while `busy`.
- `px_data` out 1: output pixel value.
- `px_x` out `X_W`: strip x, computed as digit_idx*8 + col.
- `px_y` out `CH_ROW_W`: strip y, equal to the character row.

## Operation
- **State machine:** IDLE, WAIT_RDY, READ, DRAIN, DONE.
- **IDLE / DONE:** `start`=1 latches `value` into `value_q`, clears row and digit to 0, and moves to WAIT_RDY. DONE lasts one cycle and accepts `start` like IDLE. Without `start`, DONE goes to IDLE.
- **WAIT_RDY:** when `burst_rdy`=1, move to READ next cycle. Otherwise hold; the stall is unbounded.
- **Select outputs:** `ch_sel` = `value_q` nibble for digit d. Digit 0 is `value_q[4*DIGITS-1 -: 4]`. `row_sel` = current row. Both are registered and stable from WAIT_RDY through the end of DRAIN.
- **READ:** exactly 8 cycles with `ch_px_rd`=1, then DRAIN.
- **DRAIN:** `ch_px_rd`=0. Wait until the 8th valid pixel of the burst has been passed out. Then:
  - if digit=DIGITS-1 and row=7, go to DONE;
  - otherwise advance and go to WAIT_RDY.
- **Advance order:** digit is the inner loop and row is the outer loop, i.e. all digits of row 0 first.
- **Pixel column counter:** cleared at READ entry, incremented on each `ch_px_valid`. `px_x` = {digit, col}.
- **Pixel counts:** total 8*DIGITS bursts, 64*DIGITS pixels per render.
- **Start while busy:** `start` with `busy`=1 is ignored, and `value` changes are ignored after latch.
- **Reset mid-operation:** `rst` returns to IDLE the next edge. All outputs and counters are cleared, and no `done` is produced. `hex_ch` is reset by the same `rst`.

## Timing
- **Reset values:** `busy`=0, `done`=0, `ch_px_rd`=0, `ch_sel`=0, `row_sel`=0, `px_valid`=0, `px_data`=0, `px_x`=0, `px_y`=0.
- **Start handshake:** `start` at cycle s gives `busy`=1 from s+1. The first READ is at s+2 if `burst_rdy`=1.
- **Burst pipeline:** READ at cycles t..t+7 gives `ch_px_valid` at t+2..t+9. DRAIN covers t+8..t+9, and WAIT_RDY is at t+10. The `ch_px_valid` gap before the next READ is ≥1 cycle, so `hex_ch` resets its column count.
- **Burst period:** 11 cycles with `burst_rdy` held high.
- **Completion:** the last pixel is at s+2+11*(8*DIGITS-1)+9. `done`=1 and `busy`=0 on the following cycle.
- **Output path:** `px_*` are combinational from `ch_px_valid`/`ch_px_out` plus the registered counters. No added latency.

## Configuration
- **`HEX_RENDER_LZB_EN` defined:** leading-zero blanking is on.
  - Digits left of the first nonzero nibble are blanked. The last digit is never blanked.
  - Blanked digits output `px_data`=0 for all 8 pixels.
  - The blank mask is computed once at latch.
  - Burst timing and pixel count are unchanged.
- **`HEX_RENDER_LZB_EN` undefined:** every digit is rendered from `hex_ch`, and `px_data` = `ch_px_out`.

## Test plan
- **Reset check:** assert `rst` for 3 cycles with `start`=1 -> all outputs 0, and `busy` stays 0 until `start` after reset release.
- **Full render:** `DIGITS`=4, `value`=16'h1A3F, `burst_rdy`=1, `start` at s -> the required responses are:
  - 256 pixels;
  - `ch_sel` sequence 1,A,3,F repeating per row;
  - `px_x` 0..31 within each row, with `px_y` 0..7;
  - `px_data` matches the font model;
  - `done` at s+353.
- **Flow control:** hold `burst_rdy`=0 for 20 cycles before burst 5 -> `ch_px_rd` stays 0 and the outputs hold; the render resumes and `done` arrives 20 cycles late.
- **Start while busy:** pulse `start` with `value`=16'hFFFF mid-render -> ignored, and the output still renders 1A3F.
- **Reset mid-render:** assert `rst` during burst 10 -> next cycle `busy`=0 and no `done`. A fresh start renders completely.
- **Leading-zero blanking:** with `HEX_RENDER_LZB_EN`, `value`=16'h00A0 -> digits 0-1 give all-zero pixels and digits 2-3 render 'A','0'. `value`=0 -> only digit 3 '0' is visible.
